ddr3_cmd_sequencer: RTL and testbench

DDR3_CMD_SEQUENCER -- requirements
Module: ddr3_cmd_sequencer

---
 rtl/ddr3_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ddr3_cmd_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_sequencer.sv
// DDR3 command sequencer: turns read/write requests into ACT/PRE/RD/WR command
// sequences with per-bank open-row tracking, and services refresh requests
// (precharge-all if needed, then REF) between accesses.
module ddr3_cmd_sequencer #(
  parameter int unsigned BANKS = 8,
  parameter int unsigned BA_W  = 3,
  parameter int unsigned ROW_W = 15,
  parameter int unsigned COL_W = 10,
  parameter int unsigned T_RCD = 3,
  parameter int unsigned T_RP  = 3,
  parameter int unsigned T_RFC = 20
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WR,
  input  logic              REQ_AP,
  input  logic [BA_W-1:0]   REQ_BA,
  input  logic [ROW_W-1:0]  REQ_ROW,
  input  logic [COL_W-1:0]  REQ_COL,
  input  logic              REF_REQ,
  output logic              REF_ACK,
  output logic              CS,
  output logic              RAS,
  output logic              CAS,
  output logic              WE,
  output logic [ROW_W-1:0]  Addr_out,
  output logic [BA_W-1:0]   BA_out,
  output logic [BANKS-1:0]  OPEN_BANKS
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] RcdLd = CntW'(T_RCD - 1);
  localparam logic [CntW-1:0] RpLd  = CntW'(T_RP - 1);
  localparam logic [CntW-1:0] RfcLd = CntW'(T_RFC - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // {CS,RAS,CAS,WE}
  localparam logic [3:0] CmdNop    = 4'b0111;
  localparam logic [3:0] CmdAct    = 4'b0011;
  localparam logic [3:0] CmdRd     = 4'b0101;
  localparam logic [3:0] CmdWr     = 4'b0100;
  localparam logic [3:0] CmdPre    = 4'b0010;
  localparam logic [3:0] CmdRef    = 4'b0001;
  localparam logic [3:0] CmdDesel  = 4'b1111;

  typedef enum logic [3:0] {
    StIdle, StPre, StPreWait, StAct, StActWait, StRdWr, StApWait,
    StPrea, StPreaWait, StRef, StRefWait
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [BANKS-1:0] open_q, open_d;
  logic [ROW_W-1:0] row_q [BANKS];
  logic [ROW_W-1:0] row_d [BANKS];
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [ROW_W-1:0] addr_q, addr_d;
  logic [BA_W-1:0]  ba_q, ba_d;

  logic             req_wr_q, req_wr_d;
  logic             req_ap_q, req_ap_d;
  logic [BA_W-1:0]  req_ba_q, req_ba_d;
  logic [ROW_W-1:0] req_row_q, req_row_d;
  logic [COL_W-1:0] req_col_q, req_col_d;

  logic             in_idle, ref_pend, accept, hit, any_open;
  logic             eff_wr, eff_ap;
  logic [BA_W-1:0]  eff_ba;
  logic [ROW_W-1:0] eff_row;
  logic [COL_W-1:0] eff_col;

  // A REF_REQ arriving in an idle cycle already blocks acceptance that cycle.
  assign in_idle   = (state_q == StIdle);
  assign ref_pend  = pend_q | REF_REQ;
  assign REQ_READY = RESET & in_idle & ~ref_pend;
  assign accept    = REQ_VALID & REQ_READY;
  assign hit       = open_q[REQ_BA] && (row_q[REQ_BA] == REQ_ROW);
  assign any_open  = |open_q;

  // Request fields come straight from the inputs on the accept cycle, else from the capture.
  assign eff_wr  = in_idle ? REQ_WR  : req_wr_q;
  assign eff_ap  = in_idle ? REQ_AP  : req_ap_q;
  assign eff_ba  = in_idle ? REQ_BA  : req_ba_q;
  assign eff_row = in_idle ? REQ_ROW : req_row_q;
  assign eff_col = in_idle ? REQ_COL : req_col_q;

  assign {CS, RAS, CAS, WE} = cmd_q;
  assign Addr_out   = addr_q;
  assign BA_out     = ba_q;
  assign REF_ACK    = ack_q;
  assign OPEN_BANKS = open_q;

  // FSM state and wait counter register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each command state lasts one cycle, waits count down to zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ref_pend) begin
          if (any_open) begin
            state_d = StPrea;
            cnt_d   = RpLd;
          end else begin
            state_d = StRef;
            cnt_d   = RfcLd;
          end
        end else if (REQ_VALID) begin
          if (hit) begin
            state_d = StRdWr;
          end else if (open_q[REQ_BA]) begin
            state_d = StPre;
            cnt_d   = RpLd;
          end else begin
            state_d = StAct;
            cnt_d   = RcdLd;
          end
        end
      end
      StPre, StPreWait: begin
        if (cnt_q == '0) begin
          state_d = StAct;
          cnt_d   = RcdLd;
        end else begin
          state_d = StPreWait;
          cnt_d   = cnt_q - CntOne;
        end
      end
      StAct, StActWait: begin
        if (cnt_q == '0) begin
          state_d = StRdWr;
        end else begin
          state_d = StActWait;
          cnt_d   = cnt_q - CntOne;
        end
      end
      StRdWr: begin
        if (req_ap_q) begin
          state_d = StApWait;
          cnt_d   = RpLd;
        end else begin
          state_d = StIdle;
        end
      end
      StApWait: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntOne;
      end
      StPrea, StPreaWait: begin
        if (cnt_q == '0) begin
          state_d = StRef;
          cnt_d   = RfcLd;
        end else begin
          state_d = StPreaWait;
          cnt_d   = cnt_q - CntOne;
        end
      end
      StRef, StRefWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          state_d = StRefWait;
          cnt_d   = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: the command is chosen by the state being entered, so it is on the pins in that state
  always_comb begin
    cmd_d     = CmdNop;
    addr_d    = '0;
    ba_d      = '0;
    open_d    = open_q;
    row_d     = row_q;
    ack_d     = 1'b0;
    pend_d    = pend_q | REF_REQ;
    req_wr_d  = accept ? REQ_WR  : req_wr_q;
    req_ap_d  = accept ? REQ_AP  : req_ap_q;
    req_ba_d  = accept ? REQ_BA  : req_ba_q;
    req_row_d = accept ? REQ_ROW : req_row_q;
    req_col_d = accept ? REQ_COL : req_col_q;
    unique case (state_d)
      StPre: begin
        cmd_d          = CmdPre;
        ba_d           = eff_ba;
        open_d[eff_ba] = 1'b0;
      end
      StAct: begin
        cmd_d          = CmdAct;
        ba_d           = eff_ba;
        addr_d         = eff_row;
        open_d[eff_ba] = 1'b1;
        row_d[eff_ba]  = eff_row;
      end
      StRdWr: begin
        cmd_d               = eff_wr ? CmdWr : CmdRd;
        ba_d                = eff_ba;
        addr_d[COL_W-1:0]   = eff_col;
        addr_d[10]          = eff_ap;
        addr_d[12]          = 1'b1;  // BL8
        if (eff_ap) open_d[eff_ba] = 1'b0;
      end
      StPrea: begin
        cmd_d      = CmdPre;
        addr_d[10] = 1'b1;  // precharge all
        open_d     = '0;
      end
      StRef: cmd_d = CmdRef;
      default: ;
    endcase
    if ((state_q == StRef || state_q == StRefWait) && cnt_q == '0) begin
      ack_d  = 1'b1;
      pend_d = REF_REQ;
    end
  end

  // Registered command pins, bank tracking and captured request
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cmd_q     <= CmdDesel;
      addr_q    <= '0;
      ba_q      <= '0;
      open_q    <= '0;
      for (int i = 0; i < int'(BANKS); i++) row_q[i] <= '0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      req_wr_q  <= 1'b0;
      req_ap_q  <= 1'b0;
      req_ba_q  <= '0;
      req_row_q <= '0;
      req_col_q <= '0;
    end else begin
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
      open_q    <= open_d;
      row_q     <= row_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      req_wr_q  <= req_wr_d;
      req_ap_q  <= req_ap_d;
      req_ba_q  <= req_ba_d;
      req_row_q <= req_row_d;
      req_col_q <= req_col_d;
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
// Directed bench for ddr3_cmd_sequencer with default parameters
// (8 banks, ROW_W=15, COL_W=10, tRCD=3, tRP=3, tRFC=20).
module tb_ddr3_cmd_sequencer;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_DES = 4'b1111;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WR = 1'b0;
  logic        REQ_AP = 1'b0;
  logic [2:0]  REQ_BA = '0;
  logic [14:0] REQ_ROW = '0;
  logic [9:0]  REQ_COL = '0;
  logic        REF_REQ = 1'b0;
  logic        REF_ACK;
  logic        CS, RAS, CAS, WE;
  logic [14:0] Addr_out;
  logic [2:0]  BA_out;
  logic [7:0]  OPEN_BANKS;

  logic [3:0]  cmd;
  logic [21:0] bus;
  assign cmd = {CS, RAS, CAS, WE};
  assign bus = {cmd, BA_out, Addr_out};

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ddr3_cmd_sequencer dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WR(REQ_WR), .REQ_AP(REQ_AP), .REQ_BA(REQ_BA), .REQ_ROW(REQ_ROW),
    .REQ_COL(REQ_COL), .REF_REQ(REF_REQ), .REF_ACK(REF_ACK), .CS(CS), .RAS(RAS),
    .CAS(CAS), .WE(WE), .Addr_out(Addr_out), .BA_out(BA_out), .OPEN_BANKS(OPEN_BANKS)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Presents a request and returns just after the accepting edge (cycle N);
  // the next negedge is then cycle N+1.
  task automatic issue(input logic wr, input logic ap, input logic [2:0] ba,
                       input logic [14:0] row, input logic [9:0] col);
    int n;
    @(negedge CLK);
    REQ_WR = wr; REQ_AP = ap; REQ_BA = ba; REQ_ROW = row; REQ_COL = col;
    REQ_VALID = 1'b1;
    n = 0;
    while (REQ_READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (REQ_READY !== 1'b1) begin
      failures++;
      $display("FAIL issue_timeout ready=%b want=1", REQ_READY);
    end
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({bus, REQ_READY, REF_ACK, OPEN_BANKS} !== {C_DES, 3'd0, 15'd0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", {bus, REQ_READY, REF_ACK, OPEN_BANKS},
               {C_DES, 3'd0, 15'd0, 1'b0, 1'b0, 8'h00});
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b want=1", REQ_READY);
    end
    tick(1);
    checks++;
    if ({cmd, REQ_READY} !== {C_NOP, 1'b1}) begin
      failures++; $display("FAIL reset_idle_nop got=%h want=%h", {cmd, REQ_READY}, {C_NOP, 1'b1});
    end
  endtask

  task automatic test_refresh_closed;
    @(negedge CLK);
    REF_REQ = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 1'b0) begin
      failures++; $display("FAIL refc_ready_blocked got=%b want=0", REQ_READY);
    end
    @(posedge CLK);
    #1 REF_REQ = 1'b0;
    tick(1);
    checks++;
    if (bus !== {C_REF, 3'd0, 15'd0}) begin
      failures++; $display("FAIL refc_ref got=%h want=%h", bus, {C_REF, 3'd0, 15'd0});
    end
    tick(19);
    checks++;
    if (REF_ACK !== 1'b0) begin
      failures++; $display("FAIL refc_ack_early got=%b want=0", REF_ACK);
    end
    tick(1);
    checks++;
    if ({REF_ACK, REQ_READY} !== 2'b11) begin
      failures++; $display("FAIL refc_ack got=%b want=11", {REF_ACK, REQ_READY});
    end
    tick(1);
    checks++;
    if ({REF_ACK, REQ_READY, cmd} !== {2'b01, C_NOP}) begin
      failures++; $display("FAIL refc_ack_pulse got=%h want=%h", {REF_ACK, REQ_READY, cmd}, {2'b01, C_NOP});
    end
  endtask

  task automatic test_closed_write;
    issue(1'b1, 1'b0, 3'd3, 15'h0005, 10'h007);
    tick(1);
    checks++;
    if (bus !== {C_ACT, 3'd3, 15'h0005}) begin
      failures++; $display("FAIL closed_act got=%h want=%h", bus, {C_ACT, 3'd3, 15'h0005});
    end
    tick(1);
    checks++;
    if (cmd !== C_NOP) begin
      failures++; $display("FAIL closed_gap got=%b want=%b", cmd, C_NOP);
    end
    tick(2);
    checks++;
    if ({bus, OPEN_BANKS} !== {C_WR, 3'd3, 15'h1007, 8'h08}) begin
      failures++; $display("FAIL closed_wr got=%h want=%h", {bus, OPEN_BANKS}, {C_WR, 3'd3, 15'h1007, 8'h08});
    end
    tick(1);
    checks++;
    if ({cmd, REQ_READY} !== {C_NOP, 1'b1}) begin
      failures++; $display("FAIL closed_done got=%h want=%h", {cmd, REQ_READY}, {C_NOP, 1'b1});
    end
  endtask

  task automatic test_page_hit;
    issue(1'b0, 1'b0, 3'd3, 15'h0005, 10'h011);
    tick(1);
    checks++;
    if (bus !== {C_RD, 3'd3, 15'h1011}) begin
      failures++; $display("FAIL hit_rd got=%h want=%h", bus, {C_RD, 3'd3, 15'h1011});
    end
    tick(1);
    checks++;
    if ({cmd, REQ_READY} !== {C_NOP, 1'b1}) begin
      failures++; $display("FAIL hit_done got=%h want=%h", {cmd, REQ_READY}, {C_NOP, 1'b1});
    end
  endtask

  task automatic test_page_miss;
    issue(1'b0, 1'b0, 3'd3, 15'h5D6E, 10'h3F8);
    tick(1);
    checks++;
    if (bus !== {C_PRE, 3'd3, 15'h0000}) begin
      failures++; $display("FAIL miss_pre got=%h want=%h", bus, {C_PRE, 3'd3, 15'h0000});
    end
    tick(3);
    checks++;
    if (bus !== {C_ACT, 3'd3, 15'h5D6E}) begin
      failures++; $display("FAIL miss_act got=%h want=%h", bus, {C_ACT, 3'd3, 15'h5D6E});
    end
    tick(3);
    checks++;
    if ({bus, OPEN_BANKS} !== {C_RD, 3'd3, 15'h13F8, 8'h08}) begin
      failures++; $display("FAIL miss_rd got=%h want=%h", {bus, OPEN_BANKS}, {C_RD, 3'd3, 15'h13F8, 8'h08});
    end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK);
    REQ_WR = 1'b0; REQ_AP = 1'b0; REQ_BA = 3'd3; REQ_ROW = 15'h5D6E; REQ_COL = 10'h001;
    REQ_VALID = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 1'b1) begin
      failures++; $display("FAIL b2b_ready0 got=%b want=1", REQ_READY);
    end
    @(posedge CLK);
    #1 REQ_COL = 10'h002;
    tick(1);
    checks++;
    if ({bus, REQ_READY} !== {C_RD, 3'd3, 15'h1001, 1'b0}) begin
      failures++; $display("FAIL b2b_rd1 got=%h want=%h", {bus, REQ_READY}, {C_RD, 3'd3, 15'h1001, 1'b0});
    end
    tick(1);
    checks++;
    if ({cmd, REQ_READY} !== {C_NOP, 1'b1}) begin
      failures++; $display("FAIL b2b_gap got=%h want=%h", {cmd, REQ_READY}, {C_NOP, 1'b1});
    end
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    tick(1);
    checks++;
    if (bus !== {C_RD, 3'd3, 15'h1002}) begin
      failures++; $display("FAIL b2b_rd2 got=%h want=%h", bus, {C_RD, 3'd3, 15'h1002});
    end
  endtask

  task automatic test_auto_precharge;
    issue(1'b1, 1'b1, 3'd2, 15'h0010, 10'h000);
    tick(4);
    checks++;
    if ({bus, OPEN_BANKS} !== {C_WR, 3'd2, 15'h1400, 8'h08}) begin
      failures++; $display("FAIL ap_wr got=%h want=%h", {bus, OPEN_BANKS}, {C_WR, 3'd2, 15'h1400, 8'h08});
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      checks++;
      if ({cmd, REQ_READY} !== {C_NOP, 1'b0}) begin
        failures++; $display("FAIL ap_wait%0d got=%h want=%h", i, {cmd, REQ_READY}, {C_NOP, 1'b0});
      end
    end
    tick(1);
    checks++;
    if (REQ_READY !== 1'b1) begin
      failures++; $display("FAIL ap_ready got=%b want=1", REQ_READY);
    end
  endtask

  task automatic test_refresh;
    @(negedge CLK);
    REQ_WR = 1'b0; REQ_AP = 1'b0; REQ_BA = 3'd3; REQ_ROW = 15'h0100; REQ_COL = 10'h004;
    REQ_VALID = 1'b1;
    REF_REQ = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 1'b0) begin
      failures++; $display("FAIL ref_priority got=%b want=0", REQ_READY);
    end
    @(posedge CLK);
    #1 REF_REQ = 1'b0;
    tick(1);
    checks++;
    if ({bus, OPEN_BANKS} !== {C_PRE, 3'd0, 15'h0400, 8'h00}) begin
      failures++; $display("FAIL ref_prea got=%h want=%h", {bus, OPEN_BANKS}, {C_PRE, 3'd0, 15'h0400, 8'h00});
    end
    tick(2);
    checks++;
    if (cmd !== C_NOP) begin
      failures++; $display("FAIL ref_prea_wait got=%b want=%b", cmd, C_NOP);
    end
    tick(1);
    checks++;
    if (bus !== {C_REF, 3'd0, 15'd0}) begin
      failures++; $display("FAIL ref_ref got=%h want=%h", bus, {C_REF, 3'd0, 15'd0});
    end
    tick(19);
    checks++;
    if ({REF_ACK, REQ_READY} !== 2'b00) begin
      failures++; $display("FAIL ref_wait got=%b want=00", {REF_ACK, REQ_READY});
    end
    tick(1);
    checks++;
    if ({REF_ACK, REQ_READY} !== 2'b11) begin
      failures++; $display("FAIL ref_ack got=%b want=11", {REF_ACK, REQ_READY});
    end
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    tick(1);
    checks++;
    if ({REF_ACK, bus} !== {1'b0, C_ACT, 3'd3, 15'h0100}) begin
      failures++; $display("FAIL ref_then_act got=%h want=%h", {REF_ACK, bus}, {1'b0, C_ACT, 3'd3, 15'h0100});
    end
    tick(3);
    checks++;
    if (bus !== {C_RD, 3'd3, 15'h1004}) begin
      failures++; $display("FAIL ref_then_rd got=%h want=%h", bus, {C_RD, 3'd3, 15'h1004});
    end
  endtask

  task automatic test_ref_during_access;
    int n;
    issue(1'b0, 1'b0, 3'd5, 15'h0022, 10'h008);
    tick(1);
    REF_REQ = 1'b1;
    checks++;
    if (bus !== {C_ACT, 3'd5, 15'h0022}) begin
      failures++; $display("FAIL rda_act got=%h want=%h", bus, {C_ACT, 3'd5, 15'h0022});
    end
    tick(1);
    REF_REQ = 1'b0;
    tick(2);
    checks++;
    if (bus !== {C_RD, 3'd5, 15'h1008}) begin
      failures++; $display("FAIL rda_rd got=%h want=%h", bus, {C_RD, 3'd5, 15'h1008});
    end
    tick(1);
    checks++;
    if ({cmd, REQ_READY} !== {C_NOP, 1'b0}) begin
      failures++; $display("FAIL rda_pending got=%h want=%h", {cmd, REQ_READY}, {C_NOP, 1'b0});
    end
    tick(1);
    checks++;
    if ({bus, OPEN_BANKS} !== {C_PRE, 3'd0, 15'h0400, 8'h00}) begin
      failures++; $display("FAIL rda_prea got=%h want=%h", {bus, OPEN_BANKS}, {C_PRE, 3'd0, 15'h0400, 8'h00});
    end
    n = 0;
    while (REF_ACK !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != 23) begin
      failures++; $display("FAIL rda_ack_time got=%0d want=23", n);
    end
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 1'b0, 3'd1, 15'h0033, 10'h002);
    tick(1);
    checks++;
    if ({bus, OPEN_BANKS} !== {C_ACT, 3'd1, 15'h0033, 8'h02}) begin
      failures++; $display("FAIL rst_mid_act got=%h want=%h", {bus, OPEN_BANKS}, {C_ACT, 3'd1, 15'h0033, 8'h02});
    end
    tick(1);
    RESET = 1'b0;
    tick(1);
    checks++;
    if ({bus, OPEN_BANKS, REQ_READY, REF_ACK} !== {C_DES, 3'd0, 15'd0, 8'h00, 2'b00}) begin
      failures++;
      $display("FAIL rst_mid_abort got=%h want=%h", {bus, OPEN_BANKS, REQ_READY, REF_ACK},
               {C_DES, 3'd0, 15'd0, 8'h00, 2'b00});
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 1'b1) begin
      failures++; $display("FAIL rst_mid_ready got=%b want=1", REQ_READY);
    end
    tick(1);
    checks++;
    if ({cmd, OPEN_BANKS} !== {C_NOP, 8'h00}) begin
      failures++; $display("FAIL rst_mid_no_wr got=%h want=%h", {cmd, OPEN_BANKS}, {C_NOP, 8'h00});
    end
  endtask

  initial begin
    test_reset;
    test_refresh_closed;
    test_closed_write;
    test_page_hit;
    test_page_miss;
    test_back_to_back;
    test_auto_precharge;
    test_refresh;
    test_ref_during_access;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
